cost_min_normalize: RTL and testbench
=====================================

# cost_min_normalize

Per-pixel minimum normalisation stage of the aggregate-cost path: the subtracting counterpart to the saturating `+P1`/`+P2` adders. It accepts the NDISP aggregated costs of one pixel, finds their minimum, and re-emits every cost minus that minimum, so the next path step starts from a zero-based cost vector and the adders never saturate. Double-banked (ping-pong) so one pixel is collected while the previous one drains, sustaining one cost per cycle.

## Interface
- `DATA_W`, 8: cost width in bits, input and output.
- `NDISP`, 16: disparities per pixel. Must be ≥ 2.
- `IDX_W`, 4: disparity index width. Must satisfy 2^IDX_W ≥ NDISP.

- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input cost valid.
- `in_ready` output 1: block can accept a cost this cycle.
- `in_cost` input DATA_W: aggregated cost. Disparity order is 0..NDISP-1.
- `in_last` input 1: producer's end-of-pixel marker. Checked only, never used for framing.
- `out_valid` output 1: output registers hold a valid normalised cost.
- `out_ready` input 1: downstream accepts the output.
- `out_cost` output DATA_W: `cost − min` for the current disparity.
- `out_last` output 1: high on disparity NDISP-1 of a pixel.
- `out_min` output DATA_W: minimum of the current pixel, held constant for all NDISP outputs of that pixel.
- `err_len` output 1: one-cycle pulse on an in_last framing mismatch.

## Operation
- Storage is two banks of NDISP × DATA_W registers. Each bank has a `full` flag and a `min` register.
- **Write side**
  - State: `wr_bank`, `wr_idx`, `run_min`.
  - `in_ready = !full[wr_bank]`, a purely registered term.
  - Accept (`in_valid & in_ready`): store the cost at `[wr_bank][wr_idx]`.
  - `run_min` = `in_cost` when `wr_idx == 0`, otherwise `min(run_min, in_cost)`.
  - On accepting `wr_idx == NDISP-1`:
    - set `full[wr_bank]`;
    - load `min[wr_bank]` with the final minimum, including the current cost;
    - toggle `wr_bank`;
    - reset `wr_idx` to 0.
  - Otherwise `wr_idx` increments.
- **Framing check**
  - `err_len` pulses on the cycle after an accept where `in_last != (wr_idx == NDISP-1)`.
  - Framing always follows the count; the pixel is still stored and emitted normally.
- **Read side**
  - State: `rd_bank`, `rd_idx`.
  - The output register loads when `full[rd_bank] & (!out_valid | out_ready)`:
    - `out_cost = mem[rd_bank][rd_idx] − min[rd_bank]`;
    - `out_min = min[rd_bank]`;
    - `out_last = (rd_idx == NDISP-1)`;
    - `out_valid = 1`.
  - When it loads `rd_idx == NDISP-1`: clear `full[rd_bank]`, toggle `rd_bank`, reset `rd_idx` to 0.
  - `out_valid` clears when `out_ready` is high and no new load occurs.
- **Arithmetic**
  - `min ≤ cost` always holds, so the subtraction never underflows. The result is DATA_W bits, with no saturation logic on the read side.
  - Equal costs produce 0.
- **Simultaneous events**
  - Write-fill and read-drain of different banks proceed in the same cycle.
  - A bank freed at edge N shows `in_ready` = 1 from edge N+1.
  - Setting and clearing `full` of the same bank in one cycle cannot occur.
- **Backpressure**
  - While `out_valid & !out_ready`, all outputs hold stable.
  - With both banks full, `in_ready` = 0.
- **Reset**
  - `rst` clears `full[]`, `wr_bank`, `rd_bank`, `wr_idx`, `rd_idx`, `run_min`, `err_len`, and the output registers (`out_valid`/`out_cost`/`out_last`/`out_min` = 0).
  - Bank contents are not reset.
  - A partially collected pixel is discarded; emission stops at once.
  - `in_ready` = 1 from the first cycle after reset.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `err_len` = 0; `out_cost`, `out_min` = 0.
  - `in_ready` = 1 (both `full` flags clear).
- Latency: last cost accepted at edge N → first `out_valid` after edge N+1 → last output of the pixel after edge N+NDISP, given `out_ready` held high.
- Throughput: 1 cost/cycle in and out sustained, with no bubbles between pixels when `out_ready` = 1.
- `err_len`: registered, asserted for exactly one cycle per mismatch.
- Valid/ready: AXI-stream style. Data transfers on a cycle with `valid & ready`. `valid` never depends combinationally on `ready`.

## Configuration
- `COSTNORM_LEN_CHECK_EN`
  - Defined: the in_last comparator and the `err_len` register are built.
  - Undefined: `err_len` is tied to 0 and `in_last` is ignored.
  - Data-path behaviour is identical either way.

## Test plan
The bench overrides `NDISP = 4` and `IDX_W = 2`.
- **Basic pixel:** costs 10, 3, 7, 3 with `in_last` on the 4th, `out_ready` = 1 → outputs 7, 0, 4, 0; `out_min` = 3; `out_last` only on the 4th; first `out_valid` one cycle after the 4th accept; `err_len` stays 0.
- **Streaming:** 3 back-to-back pixels (255,255,255,255), (0,9,1,2), (200,100,150,100) with `out_ready` = 1 → outputs 0,0,0,0 / 0,9,1,2 / 100,0,50,0; `in_ready` never drops; no output gaps.
- **Backpressure:** `out_ready` = 0 while 3 pixels are offered → `in_ready` drops after 8 accepts; outputs hold stable; raising `out_ready` drains the pixels in order.
- **Framing error:** `in_last` asserted on index 1 and deasserted on index 3 → two `err_len` pulses; output is still 4 correctly normalised values. With the macro undefined, `err_len` stays 0.
- **Reset mid-operation:** assert `rst` after 2 accepts, and separately during drain → all outputs 0 next cycle; `in_ready` = 1; a following pixel 5, 6, 7, 8 emits 0, 1, 2, 3 with `out_min` = 5.

Source files
------------

// File: rtl/cost_min_normalize.sv
// Per-pixel minimum normalisation with ping-pong cost banks, one cost per cycle in and out.
// Define COSTNORM_LEN_CHECK_EN to build the in_last framing comparator driving err_len.
module cost_min_normalize #(
  parameter int DATA_W = 8,
  parameter int NDISP  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_cost,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_cost,
  output logic              out_last,
  output logic [DATA_W-1:0] out_min,
  output logic              err_len
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDISP - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [DATA_W-1:0] mem_q [2][NDISP];
  logic [DATA_W-1:0] min_q [2];

  logic [1:0]        full_q, full_d;
  logic              wrBank_q, wrBank_d;
  logic [IDX_W-1:0]  wrIdx_q, wrIdx_d;
  logic [DATA_W-1:0] runMin_q, runMin_d;
  logic              rdBank_q, rdBank_d;
  logic [IDX_W-1:0]  rdIdx_q, rdIdx_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outCost_q, outCost_d;
  logic              outLast_q, outLast_d;
  logic [DATA_W-1:0] outMin_q, outMin_d;

  logic              accept;
  logic              wrLast;
  logic              rdLast;
  logic              rdLoad;
  logic [DATA_W-1:0] candMin;

  assign in_ready = !full_q[wrBank_q];
  assign accept   = in_valid && in_ready;
  assign wrLast   = (wrIdx_q == LAST_IDX);
  assign rdLast   = (rdIdx_q == LAST_IDX);
  assign rdLoad   = full_q[rdBank_q] && (!outValid_q || out_ready);

  // The first cost of a pixel restarts the running minimum.
  always_comb begin
    candMin = in_cost;
    if ((wrIdx_q != '0) && (runMin_q < in_cost)) begin
      candMin = runMin_q;
    end
  end

  always_comb begin
    full_d     = full_q;
    wrBank_d   = wrBank_q;
    wrIdx_d    = wrIdx_q;
    runMin_d   = runMin_q;
    rdBank_d   = rdBank_q;
    rdIdx_d    = rdIdx_q;
    outValid_d = outValid_q;
    outCost_d  = outCost_q;
    outLast_d  = outLast_q;
    outMin_d   = outMin_q;

    if (accept) begin
      runMin_d = candMin;
      if (wrLast) begin
        full_d[wrBank_q] = 1'b1;
        wrBank_d         = !wrBank_q;
        wrIdx_d          = '0;
      end else begin
        wrIdx_d = wrIdx_q + IDX_ONE;
      end
    end

    // Write only targets an empty bank and read only a full one, so they never collide.
    if (rdLoad) begin
      outValid_d = 1'b1;
      outCost_d  = mem_q[rdBank_q][rdIdx_q] - min_q[rdBank_q];
      outMin_d   = min_q[rdBank_q];
      outLast_d  = rdLast;
      if (rdLast) begin
        full_d[rdBank_q] = 1'b0;
        rdBank_d         = !rdBank_q;
        rdIdx_d          = '0;
      end else begin
        rdIdx_d = rdIdx_q + IDX_ONE;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wrBank_q   <= 1'b0;
      wrIdx_q    <= '0;
      runMin_q   <= '0;
      rdBank_q   <= 1'b0;
      rdIdx_q    <= '0;
      outValid_q <= 1'b0;
      outCost_q  <= '0;
      outLast_q  <= 1'b0;
      outMin_q   <= '0;
    end else begin
      full_q     <= full_d;
      wrBank_q   <= wrBank_d;
      wrIdx_q    <= wrIdx_d;
      runMin_q   <= runMin_d;
      rdBank_q   <= rdBank_d;
      rdIdx_q    <= rdIdx_d;
      outValid_q <= outValid_d;
      outCost_q  <= outCost_d;
      outLast_q  <= outLast_d;
      outMin_q   <= outMin_d;
    end
  end

  // Bank storage carries no reset; a bank is only read after it has been completely refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wrBank_q][wrIdx_q] <= in_cost;
      if (wrLast) begin
        min_q[wrBank_q] <= candMin;
      end
    end
  end

`ifdef COSTNORM_LEN_CHECK_EN
  logic errLen_q, errLen_d;

  assign errLen_d = accept && (in_last != wrLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      errLen_q <= 1'b0;
    end else begin
      errLen_q <= errLen_d;
    end
  end

  assign err_len = errLen_q;
`else
  logic unusedInLast;

  assign unusedInLast = in_last;
  assign err_len      = 1'b0;
`endif

  assign out_valid = outValid_q;
  assign out_cost  = outCost_q;
  assign out_last  = outLast_q;
  assign out_min   = outMin_q;

endmodule

// File: tb/tb_cost_min_normalize.sv
// Self-checking bench for cost_min_normalize with NDISP = 4: vector table, corner sequences
// and a randomized run scored against a whole-pixel reference model.
module tb_cost_min_normalize;

  localparam int DATA_W = 8;
  localparam int NDISP  = 4;
  localparam int IDX_W  = 2;
  localparam int NVEC   = 7;

`ifdef COSTNORM_LEN_CHECK_EN
  localparam int EXP_FRAME_ERR = 2;
`else
  localparam int EXP_FRAME_ERR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_cost;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_cost;
  logic              out_last;
  logic [DATA_W-1:0] out_min;
  logic              err_len;

  always #5 clk = ~clk;

  cost_min_normalize #(
    .DATA_W(DATA_W),
    .NDISP (NDISP),
    .IDX_W (IDX_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cost  (in_cost),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cost (out_cost),
    .out_last (out_last),
    .out_min  (out_min),
    .err_len  (err_len)
  );

  typedef struct {
    logic [DATA_W-1:0] cost;
    logic [DATA_W-1:0] mn;
    logic              last;
    int                cyc;
  } outRec_t;

  typedef struct {
    logic [NDISP-1:0][DATA_W-1:0] cost;
    logic [NDISP-1:0][DATA_W-1:0] norm;
    logic [DATA_W-1:0]            mn;
  } vector_t;

  outRec_t gotQ [$];
  outRec_t expQ [$];
  int      gotRd      = 0;
  int      expRd      = 0;
  int      checkCount = 0;
  int      errorCount = 0;
  int      cyc        = 0;
  int      holdViol   = 0;
  int      errHigh    = 0;
  int      readyLow   = 0;
  vector_t vecs [NVEC];

  // Monitor and reference model: completed pixels are normalised as a whole vector.
  initial begin : monitor
    logic [DATA_W-1:0] partial [$];
    logic [DATA_W-1:0] mn;
    logic              prevHold;
    logic [DATA_W-1:0] prevCost, prevMin;
    logic              prevLast;
    outRec_t           rec;
    prevHold = 1'b0;
    prevCost = '0;
    prevMin  = '0;
    prevLast = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        partial.delete();
        prevHold = 1'b0;
      end else begin
        if (prevHold && (!out_valid || out_cost != prevCost || out_min != prevMin ||
                         out_last != prevLast)) holdViol++;
        if (err_len) errHigh++;
        if (in_valid && !in_ready) readyLow++;
        if (in_valid && in_ready) begin
          partial.push_back(in_cost);
          if (partial.size() == NDISP) begin
            mn = partial[0];
            foreach (partial[k]) if (partial[k] < mn) mn = partial[k];
            foreach (partial[k]) begin
              rec.cost = partial[k] - mn;
              rec.mn   = mn;
              rec.last = (k == NDISP - 1);
              rec.cyc  = 0;
              expQ.push_back(rec);
            end
            partial.delete();
          end
        end
        if (out_valid && out_ready) begin
          rec.cost = out_cost;
          rec.mn   = out_min;
          rec.last = out_last;
          rec.cyc  = cyc;
          gotQ.push_back(rec);
        end
        prevHold = out_valid && !out_ready;
        prevCost = out_cost;
        prevMin  = out_min;
        prevLast = out_last;
      end
    end
  end

  function automatic vector_t mkVec(input int c0, input int c1, input int c2, input int c3,
                                    input int n0, input int n1, input int n2, input int n3,
                                    input int mn);
    vector_t v;
    v.cost[0] = DATA_W'(c0);
    v.cost[1] = DATA_W'(c1);
    v.cost[2] = DATA_W'(c2);
    v.cost[3] = DATA_W'(c3);
    v.norm[0] = DATA_W'(n0);
    v.norm[1] = DATA_W'(n1);
    v.norm[2] = DATA_W'(n2);
    v.norm[3] = DATA_W'(n3);
    v.mn      = DATA_W'(mn);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] cost, input logic last);
    int budget;
    budget   = 200;
    in_valid = 1'b1;
    in_cost  = cost;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) checkOutput("send_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitOutputs(input int n);
    int budget;
    budget = 500;
    while ((gotQ.size() - gotRd) < n && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if ((gotQ.size() - gotRd) < n) checkOutput("output_timeout", gotQ.size() - gotRd, n);
  endtask

  task automatic checkPixel(input string tag, input vector_t v);
    outRec_t g;
    waitOutputs(NDISP);
    if ((gotQ.size() - gotRd) < NDISP) return;
    for (int k = 0; k < NDISP; k++) begin
      g = gotQ[gotRd];
      checkOutput($sformatf("%s_cost%0d", tag, k), g.cost, v.norm[k]);
      checkOutput($sformatf("%s_min%0d", tag, k), g.mn, v.mn);
      checkOutput($sformatf("%s_last%0d", tag, k), g.last, (k == NDISP - 1) ? 1 : 0);
      if (expRd < expQ.size()) begin
        checkOutput($sformatf("%s_model%0d", tag, k), g.cost, expQ[expRd].cost);
      end else begin
        checkOutput($sformatf("%s_model_missing%0d", tag, k), expQ.size() - expRd, 1);
      end
      gotRd++;
      expRd++;
    end
  endtask

  task automatic sendPixel(input vector_t v);
    for (int k = 0; k < NDISP; k++) applyStimulus(v.cost[k], k == NDISP - 1);
  endtask

  task automatic doReset(input string tag);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    gotRd = gotQ.size();
    expRd = expQ.size();
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_cost"}, out_cost, 0);
    checkOutput({tag, "_out_last"}, out_last, 0);
    checkOutput({tag, "_out_min"}, out_min, 0);
    checkOutput({tag, "_err_len"}, err_len, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainFlow
    int e0, r0, h0, startG, gaps, acc, total, idx, budget;
    logic took;
    logic [DATA_W-1:0] bp [$];
    logic [DATA_W-1:0] rc [$];
    logic [NDISP-1:0] badLast;
    outRec_t g, e;

    vecs[0] = mkVec( 10,   3,   7,   3,    7,   0,   4,   0,    3);
    vecs[1] = mkVec(255, 255, 255, 255,    0,   0,   0,   0,  255);
    vecs[2] = mkVec(  0,   9,   1,   2,    0,   9,   1,   2,    0);
    vecs[3] = mkVec(200, 100, 150, 100,  100,   0,  50,   0,  100);
    vecs[4] = mkVec(  5,   6,   7,   8,    0,   1,   2,   3,    5);
    vecs[5] = mkVec( 40,  30,  20,  10,   30,  20,  10,   0,   10);
    vecs[6] = mkVec(  1, 254,   0, 255,    1, 254,   0, 255,    0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cost   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    doReset("reset");

    // Basic pixel with first-output latency.
    e0 = errHigh;
    sendPixel(vecs[0]);
    checkOutput("basic_valid_before", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("basic_valid_after", out_valid, 1);
    checkOutput("basic_first_cost", out_cost, 7);
    checkOutput("basic_first_min", out_min, 3);
    checkPixel("basic", vecs[0]);
    checkOutput("basic_err", errHigh - e0, 0);

    // Whole table streamed back to back.
    r0     = readyLow;
    startG = gotRd;
    for (int v = 0; v < NVEC; v++) sendPixel(vecs[v]);
    for (int v = 0; v < NVEC; v++) checkPixel($sformatf("vec%0d", v), vecs[v]);
    gaps = 0;
    for (int i = startG + 1; i < startG + NVEC * NDISP && i < gotQ.size(); i++) begin
      if (gotQ[i].cyc != gotQ[i-1].cyc + 1) gaps++;
    end
    checkOutput("stream_gaps", gaps, 0);
    checkOutput("stream_ready_drop", readyLow - r0, 0);

    // Backpressure: three pixels offered with the output stalled.
    for (int k = 0; k < NDISP; k++) bp.push_back(vecs[3].cost[k]);
    for (int k = 0; k < NDISP; k++) bp.push_back(vecs[5].cost[k]);
    for (int k = 0; k < NDISP; k++) bp.push_back(vecs[6].cost[k]);
    h0        = holdViol;
    out_ready = 1'b0;
    acc       = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_cost  = bp[acc];
      in_last  = ((acc % NDISP) == NDISP - 1);
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) acc++;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepts", acc, 2 * NDISP);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_out_cost", out_cost, 100);
    out_ready = 1'b1;
    for (int k = acc; k < 3 * NDISP; k++) applyStimulus(bp[k], (k % NDISP) == NDISP - 1);
    checkPixel("bp0", vecs[3]);
    checkPixel("bp1", vecs[5]);
    checkPixel("bp2", vecs[6]);
    checkOutput("bp_hold_stable", holdViol - h0, 0);

    // Misplaced in_last: early on index 1, missing on index 3.
    e0      = errHigh;
    badLast = 4'b0010;
    for (int k = 0; k < NDISP; k++) applyStimulus(vecs[0].cost[k], badLast[k]);
    checkPixel("frame", vecs[0]);
    checkOutput("frame_err_pulses", errHigh - e0, EXP_FRAME_ERR);

    // Reset with a partially collected pixel.
    applyStimulus(8'd99, 1'b0);
    applyStimulus(8'd1, 1'b0);
    doReset("rst_partial");
    sendPixel(vecs[4]);
    checkPixel("after_partial", vecs[4]);

    // Reset while a pixel drains.
    sendPixel(vecs[5]);
    waitOutputs(1);
    doReset("rst_drain");
    sendPixel(vecs[4]);
    checkPixel("after_drain", vecs[4]);

    // Randomized traffic and output stalls against the reference model.
    e0     = errHigh;
    total  = 30 * NDISP;
    for (int i = 0; i < total; i++) begin
      if ($urandom_range(0, 1) == 0) rc.push_back(DATA_W'($urandom_range(0, 3)));
      else rc.push_back(DATA_W'($urandom_range(0, 255)));
    end
    idx    = 0;
    budget = 5000;
    while (idx < total && budget > 0) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_cost   = rc[idx];
      in_last   = ((idx % NDISP) == NDISP - 1);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
      budget--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("rand_sent", idx, total);
    waitOutputs(total);
    for (int i = 0; i < total && gotRd < gotQ.size() && expRd < expQ.size(); i++) begin
      g = gotQ[gotRd];
      e = expQ[expRd];
      checkOutput($sformatf("rand_cost%0d", i), g.cost, e.cost);
      checkOutput($sformatf("rand_min%0d", i), g.mn, e.mn);
      checkOutput($sformatf("rand_last%0d", i), g.last, e.last);
      gotRd++;
      expRd++;
    end
    checkOutput("rand_err", errHigh - e0, 0);
    checkOutput("hold_stable_total", holdViol, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
